// File: rtl/radial_cfg_pkg.sv
// Shared types and constants for the radial zone filter configuration path.
// Also provides the saturated r^2 helper used by RTL and host-side models.
package radial_cfg_pkg;

  typedef enum logic [1:0] {
    CFG_C      = 2'd0,
    CFG_Z      = 2'd1,
    CFG_ZMIN   = 2'd2,
    CFG_RADIUS = 2'd3
  } cfg_field_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SQUARE = 2'd1,
    ST_ARMED  = 2'd2
  } cfg_state_e;

  localparam logic [17:0] R2_MAX        = 18'h3FFFF;
  localparam logic [15:0] DEPTH_INVALID = 16'hFFFF;

  typedef struct packed {
    logic [15:0] c;
    logic [15:0] z;
    logic [15:0] z_min;
    logic [17:0] r_squared;
  } zone_cfg_t;

  localparam zone_cfg_t ZONE_CFG_RST = '{c: '0, z: DEPTH_INVALID, z_min: '0, r_squared: '0};

  function automatic logic [17:0] r2_sat(input logic [15:0] radius);
    logic [31:0] w_prod;
    w_prod = 32'(radius) * 32'(radius);
    return (w_prod > 32'(R2_MAX)) ? R2_MAX : w_prod[17:0];
  endfunction

endpackage

// File: rtl/radial_r2_sat.sv
// Registered 16x16 square saturated to 18 bits; loads only when en_i is high.
module radial_r2_sat
  import radial_cfg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] radius_i,
  output logic [17:0] r2_o
);

  logic [17:0] r_r2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_r2 <= '0;
    end else if (en_i) begin
      r_r2 <= r2_sat(radius_i);
    end
  end

  assign r2_o = r_r2;

endmodule

// File: rtl/radial_zone_cfg_ctrl.sv
// Zone parameter controller: host writes fill a shadow bank, which is copied
// into the active bank in one edge at the first frame boundary after a commit.
module radial_zone_cfg_ctrl
  import radial_cfg_pkg::*;
#(
  parameter int unsigned NO_ZONES = 1,
  parameter int unsigned ZONE_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ZONE_W-1:0] wr_zone_i,
  input  logic [1:0]        wr_field_i,
  input  logic [15:0]       wr_data_i,
  input  logic              commit_i,
  input  logic              frame_end_i,
  output logic [15:0]       c_o         [NO_ZONES],
  output logic [15:0]       z_o         [NO_ZONES],
  output logic [15:0]       z_min_o     [NO_ZONES],
  output logic [17:0]       r_squared_o [NO_ZONES],
  output logic              commit_pending_o,
  output logic              commit_done_o,
  output logic              wr_err_o,
  output logic [15:0]       frames_since_commit_o
);

  cfg_state_e        r_state, w_state_nxt;
  logic              r_arm_flag, w_arm_flag_nxt;
  logic [ZONE_W-1:0] r_sq_zone;
  zone_cfg_t         r_shadow [NO_ZONES];
  zone_cfg_t         r_active [NO_ZONES];
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_frames;

  logic              w_accept;
  logic              w_zone_ok;
  logic              w_sq_en;
  logic              w_swap;
  logic [17:0]       w_r2;
  cfg_field_e        w_field;

  assign w_field    = cfg_field_e'(wr_field_i);
  assign wr_ready_o = (r_state == ST_IDLE) && !rst_i;
  assign w_accept   = wr_valid_i && wr_ready_o;
  assign w_zone_ok  = 32'(wr_zone_i) < NO_ZONES;
  assign w_sq_en    = w_accept && (w_field == CFG_RADIUS);
  assign w_swap     = (r_state == ST_ARMED) && frame_end_i;

  // Squarer loads on the accepting edge, so its output is ready during SQUARE.
  radial_r2_sat u_r2_sat (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (w_sq_en),
    .radius_i (wr_data_i),
    .r2_o     (w_r2)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_arm_flag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_arm_flag <= w_arm_flag_nxt;
    end
  end

  // A commit arriving with a radius write is remembered until SQUARE finishes.
  always_comb begin
    w_state_nxt    = r_state;
    w_arm_flag_nxt = r_arm_flag;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sq_en) begin
          w_state_nxt    = ST_SQUARE;
          w_arm_flag_nxt = commit_i;
        end else if (commit_i) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_SQUARE: begin
        w_state_nxt    = (r_arm_flag || commit_i) ? ST_ARMED : ST_IDLE;
        w_arm_flag_nxt = 1'b0;
      end
      ST_ARMED: begin
        if (frame_end_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sq_zone <= '0;
    end else if (w_sq_en) begin
      r_sq_zone <= wr_zone_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned z = 0; z < NO_ZONES; z++) r_shadow[z] <= ZONE_CFG_RST;
    end else begin
      for (int unsigned z = 0; z < NO_ZONES; z++) begin
        if (w_accept && w_zone_ok && (32'(wr_zone_i) == z)) begin
          case (w_field)
            CFG_C:    r_shadow[z].c     <= wr_data_i;
            CFG_Z:    r_shadow[z].z     <= wr_data_i;
            CFG_ZMIN: r_shadow[z].z_min <= wr_data_i;
            default:  ;
          endcase
        end
        if ((r_state == ST_SQUARE) && (32'(r_sq_zone) == z)) begin
          r_shadow[z].r_squared <= w_r2;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned z = 0; z < NO_ZONES; z++) r_active[z] <= ZONE_CFG_RST;
    end else if (w_swap) begin
      for (int unsigned z = 0; z < NO_ZONES; z++) r_active[z] <= r_shadow[z];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_frames <= '0;
    end else begin
      r_done <= w_swap;
      r_err  <= w_accept && !w_zone_ok;
      if (w_swap) begin
        r_frames <= '0;
      end else if (frame_end_i && (r_frames != '1)) begin
        r_frames <= r_frames + 16'd1;
      end
    end
  end

  always_comb begin
    for (int unsigned z = 0; z < NO_ZONES; z++) begin
      c_o[z]         = r_active[z].c;
      z_o[z]         = r_active[z].z;
      z_min_o[z]     = r_active[z].z_min;
      r_squared_o[z] = r_active[z].r_squared;
    end
  end

  assign commit_pending_o      = (r_state == ST_ARMED);
  assign commit_done_o         = r_done;
  assign wr_err_o              = r_err;
  assign frames_since_commit_o = r_frames;

endmodule

// File: tb/tb_radial_zone_cfg_ctrl.sv
// Bench for radial_zone_cfg_ctrl: directed scenarios plus random traffic,
// all checked against a transaction-level model of the two banks.
module tb_radial_zone_cfg_ctrl;

  localparam int unsigned N  = 2;
  localparam int unsigned ZW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [ZW-1:0] wr_zone;
  logic [1:0]    wr_field;
  logic [15:0]   wr_data;
  logic          commit;
  logic          frame_end;
  logic [15:0]   c_o   [N];
  logic [15:0]   z_o   [N];
  logic [15:0]   zmin_o[N];
  logic [17:0]   r2_o  [N];
  logic          pending;
  logic          done;
  logic          err;
  logic [15:0]   frames;

  always #5 clk = ~clk;

  radial_zone_cfg_ctrl #(.NO_ZONES(N), .ZONE_W(ZW)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .wr_valid_i            (wr_valid),
    .wr_ready_o            (wr_ready),
    .wr_zone_i             (wr_zone),
    .wr_field_i            (wr_field),
    .wr_data_i             (wr_data),
    .commit_i              (commit),
    .frame_end_i           (frame_end),
    .c_o                   (c_o),
    .z_o                   (z_o),
    .z_min_o               (zmin_o),
    .r_squared_o           (r2_o),
    .commit_pending_o      (pending),
    .commit_done_o         (done),
    .wr_err_o              (err),
    .frames_since_commit_o (frames)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: shadow/active banks as plain arrays, plus a pending
  // radius result and an "armed" flag.
  int unsigned m_sh_c[N], m_sh_z[N], m_sh_zmin[N], m_sh_r2[N];
  int unsigned m_ac_c[N], m_ac_z[N], m_ac_zmin[N], m_ac_r2[N];
  bit          m_sq_pend, m_armed, m_arm_req, m_done, m_err;
  int unsigned m_sq_zone, m_sq_val, m_frames;

  function automatic int unsigned sq_sat(input int unsigned r);
    longint unsigned p;
    p = longint'(r) * longint'(r);
    return (p > 64'd262143) ? 32'd262143 : 32'(p);
  endfunction

  function automatic bit exp_ready();
    return !rst && !m_armed && !m_sq_pend;
  endfunction

  task automatic model_reset();
    for (int z = 0; z < N; z++) begin
      m_sh_c[z] = 0; m_sh_z[z] = 32'hFFFF; m_sh_zmin[z] = 0; m_sh_r2[z] = 0;
      m_ac_c[z] = 0; m_ac_z[z] = 32'hFFFF; m_ac_zmin[z] = 0; m_ac_r2[z] = 0;
    end
    m_sq_pend = 0; m_armed = 0; m_arm_req = 0; m_done = 0; m_err = 0;
    m_sq_zone = 0; m_sq_val = 0; m_frames = 0;
  endtask

  task automatic model_edge();
    bit acc, was_armed;
    int unsigned zn;
    if (rst) begin
      model_reset();
      return;
    end
    acc       = wr_valid && exp_ready();
    was_armed = m_armed;
    zn        = 32'(wr_zone);
    m_done    = 0;
    m_err     = acc && (zn >= N);
    if (frame_end) begin
      if (was_armed) begin
        m_ac_c = m_sh_c; m_ac_z = m_sh_z; m_ac_zmin = m_sh_zmin; m_ac_r2 = m_sh_r2;
        m_frames = 0; m_armed = 0; m_done = 1;
      end else if (m_frames < 32'hFFFF) begin
        m_frames++;
      end
    end
    if (m_sq_pend) begin
      if (m_sq_zone < N) m_sh_r2[m_sq_zone] = m_sq_val;
      m_sq_pend = 0;
      if (m_arm_req || commit) m_armed = 1;
      m_arm_req = 0;
    end else if (!was_armed) begin
      if (acc && zn < N) begin
        case (wr_field)
          2'd0: m_sh_c[zn]    = 32'(wr_data);
          2'd1: m_sh_z[zn]    = 32'(wr_data);
          2'd2: m_sh_zmin[zn] = 32'(wr_data);
          default: ;
        endcase
      end
      if (acc && wr_field == 2'd3) begin
        m_sq_pend = 1; m_sq_zone = zn; m_sq_val = sq_sat(32'(wr_data)); m_arm_req = commit;
      end else if (commit) begin
        m_armed = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int z = 0; z < N; z++) begin
      chk($sformatf("c%0d", z),    32'(c_o[z]),    m_ac_c[z]);
      chk($sformatf("z%0d", z),    32'(z_o[z]),    m_ac_z[z]);
      chk($sformatf("zmin%0d", z), 32'(zmin_o[z]), m_ac_zmin[z]);
      chk($sformatf("r2_%0d", z),  32'(r2_o[z]),   m_ac_r2[z]);
    end
    chk("ready",   32'(wr_ready), 32'(exp_ready()));
    chk("pending", 32'(pending),  32'(m_armed));
    chk("done",    32'(done),     32'(m_done));
    chk("err",     32'(err),      32'(m_err));
    chk("frames",  32'(frames),   m_frames);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [ZW-1:0] zn, input logic [1:0] f,
                       input logic [15:0] d, input logic cm, input logic fe);
    wr_valid = v; wr_zone = zn; wr_field = f; wr_data = d; commit = cm; frame_end = fe;
  endtask

  task automatic idle();
    drive(1'b0, '0, 2'd0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    repeat (3) cycle();
    chk("rst_c0", 32'(c_o[0]), 32'd0);
    chk("rst_z0", 32'(z_o[0]), 32'hFFFF);
    chk("rst_r2_1", 32'(r2_o[1]), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);

    // radius 100 and c, commit with the c write, then frame_end
    drive(1'b1, 2'd0, 2'd3, 16'd100, 1'b0, 1'b0); cycle();
    idle(); cycle();
    drive(1'b1, 2'd0, 2'd0, 16'h3C00, 1'b1, 1'b0); cycle();
    idle(); cycle();
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b1); cycle();
    chk("t2_r2", 32'(r2_o[0]), 32'd10000);
    chk("t2_c", 32'(c_o[0]), 32'h3C00);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_frames", 32'(frames), 32'd0);
    idle(); cycle();
    chk("t2_done_once", 32'(done), 32'd0);

    // saturating radius, commit during SQUARE
    drive(1'b1, 2'd0, 2'd3, 16'd600, 1'b0, 1'b0); cycle();
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0); cycle();
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b1); cycle();
    chk("t3_sat", 32'(r2_o[0]), 32'h3FFFF);
    drive(1'b1, 2'd0, 2'd3, 16'd511, 1'b0, 1'b0); cycle();
    idle(); cycle();
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0); cycle();
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b1); cycle();
    chk("t3_nosat", 32'(r2_o[0]), 32'h3FC01);

    // commit and frame_end together from IDLE: swap waits one frame
    drive(1'b1, 2'd0, 2'd3, 16'd7, 1'b0, 1'b0); cycle();
    idle(); cycle();
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b1); cycle();
    chk("t4_pending", 32'(pending), 32'd1);
    chk("t4_hold", 32'(r2_o[0]), 32'h3FC01);
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b1); cycle();
    chk("t4_swap", 32'(r2_o[0]), 32'd49);
    chk("t4_unarmed", 32'(pending), 32'd0);

    // write held off while ARMED
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0); cycle();
    drive(1'b1, 2'd0, 2'd1, 16'h1234, 1'b0, 1'b0); cycle();
    chk("t5_stall0", 32'(wr_ready), 32'd0);
    cycle();
    chk("t5_stall1", 32'(wr_ready), 32'd0);
    drive(1'b1, 2'd0, 2'd1, 16'h1234, 1'b0, 1'b1); cycle();
    chk("t5_ready_after", 32'(wr_ready), 32'd1);
    drive(1'b1, 2'd0, 2'd1, 16'h1234, 1'b0, 1'b0); cycle();
    idle(); cycle();
    chk("t5_z_active", 32'(z_o[0]), 32'hFFFF);

    // out-of-range zone, then reset while ARMED
    drive(1'b1, 2'd3, 2'd0, 16'h5555, 1'b0, 1'b0); cycle();
    chk("t6_err", 32'(err), 32'd1);
    idle(); cycle();
    chk("t6_err_pulse", 32'(err), 32'd0);
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0); cycle();
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b1); cycle();
    chk("t6_c1", 32'(c_o[1]), 32'd0);
    chk("t6_c0", 32'(c_o[0]), 32'h3C00);
    chk("t6_z0", 32'(z_o[0]), 32'h1234);
    drive(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0); cycle();
    chk("t6_armed", 32'(pending), 32'd1);
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_pending", 32'(pending), 32'd0);
    chk("t6_rst_r2", 32'(r2_o[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 700)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
